// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, addresses the synchronous instruction ROM
// and pairs each returned word with its PC and a valid flag.
// Latency: 1 cycle from Addr to instr; 1 instr/cycle; redirect target shows next cycle.
// Backpressure: stall holds instr/instr_pc/instr_valid by re-reading the held word.
//
// Ports:
//   clk, rst          - rising-edge clock (shared with ROM), async active-high reset
//   stall             - decode not accepting; hold current output instruction
//   redirect          - load redirect_pc as next fetch target (wins over stall)
//   redirect_pc       - target byte address, bits [1:0] ignored
//   Addr              - ROM word address, sampled by the ROM on posedge clk
//   IR                - ROM read data, valid the cycle after Addr was sampled
//   instr, instr_pc   - fetched instruction (0 when not valid) and its byte PC
//   instr_valid       - instr/instr_pc hold a real fetch
//   fetch_cnt         - count of accepted instructions, wraps modulo 2^32
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       IR,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  output logic [31:0]       fetch_cnt
);

  logic [31:0] r_fpc;   // next PC to fetch
  logic [31:0] r_ipc;   // PC of the word in flight / on the output
  logic        r_ival;
  logic [31:0] r_cnt;

  logic [31:0] w_tgt;
  logic        w_hold;
  logic        w_accept;
  logic        w_unused;

  assign w_tgt    = {redirect_pc[31:2], 2'b00};
  // Holding only makes sense once a real word is on the output; before that
  // a stall is ignored and fetch proceeds.
  assign w_hold   = stall & r_ival;
  // The word shown during a redirect cycle is the delay slot: it is consumed.
  assign w_accept = r_ival & (~stall | redirect);
  assign w_unused = ^redirect_pc[1:0];

  // The ROM latches regs[Addr] every edge with no enable, so what appears on
  // IR next cycle is steered purely here. Re-reading ipc keeps IR constant
  // through a stall.
  always_comb begin
    Addr = r_fpc[ADDR_W+1:2];
    if (rst) begin
      Addr = RESET_PC[ADDR_W+1:2];
    end else if (redirect) begin
      Addr = redirect_pc[ADDR_W+1:2];
    end else if (w_hold) begin
      Addr = r_ipc[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc  <= RESET_PC;
      r_ipc  <= RESET_PC;
      r_ival <= 1'b0;
    end else if (redirect) begin
      r_ipc  <= w_tgt;
      r_fpc  <= w_tgt + 32'd4;
      r_ival <= 1'b1;
    end else if (!w_hold) begin
      r_ipc  <= r_fpc;
      r_fpc  <= r_fpc + 32'd4;
      r_ival <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 32'd0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign instr       = r_ival ? IR : 32'd0;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_ival;
  assign fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  localparam logic [31:0] RP = 32'h0000_0000;
  localparam int          AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] Addr;
  logic [31:0]   IR;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic [31:0]   fetch_cnt;

  logic [31:0] rom [1024];

  always #5 clk = ~clk;

  // Synchronous ROM: latches rom[Addr] every edge, no enable.
  always @(posedge clk) IR <= rom[Addr];

  ifu #(.RESET_PC(RP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .Addr(Addr), .IR(IR), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fetch_cnt(fetch_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what is on the output now, and how many were consumed.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return rom[pc[AW+1:2]];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = RP;
    m_cnt   = 32'd0;
  endtask

  // Drive inputs away from the edge, then check all outputs and the ROM address.
  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
    logic [31:0] nxt;
    logic [31:0] ea;
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    #1;
    if (r) model_reset();
    nxt = m_valid ? m_pc + 32'd4 : RP;
    if (r)                 ea = RP;
    else if (d)            ea = t;
    else if (s && m_valid) ea = m_pc;
    else                   ea = nxt;
    chk("Addr", 32'(Addr), 32'(ea[AW+1:2]));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr_pc", instr_pc, m_pc);
    chk("instr", instr, m_valid ? word_at(m_pc) : 32'd0);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // Advance the model at the clock edge using the currently driven inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_valid && (!stall || redirect)) m_cnt = m_cnt + 32'd1;
      if (redirect) begin
        m_pc    = redirect_pc & ~32'd3;
        m_valid = 1'b1;
      end else if (!(stall && m_valid)) begin
        m_pc    = m_valid ? m_pc + 32'd4 : RP;
        m_valid = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + 32'(i);
    model_reset();

    // Reset state
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();

    // Sequential fetch
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0);
      chk("seq_instr", instr, 32'h1000_0000 + 32'(k));
      chk("seq_pc", instr_pc, 32'(4 * k));
      chk("seq_cnt", fetch_cnt, 32'(k));
      tick();
    end

    // Redirect from pc 4 to 0x103 (treated as 0x100)
    drive(0, 0, 1, 32'h4); tick();
    drive(0, 0, 1, 32'h103);
    chk("redir_src_pc", instr_pc, 32'h4);
    tick();
    drive(0, 0, 0, 0);
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_instr", instr, 32'h1000_0040);
    tick();
    drive(0, 0, 0, 0);
    chk("redir_next_pc", instr_pc, 32'h104);
    tick();

    // Stall hold at pc 8
    drive(0, 0, 1, 32'h8); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0);
      chk("stall_instr", instr, 32'h1000_0002);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_addr", 32'(Addr), 32'd2);
      tick();
    end
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("post_stall_pc", instr_pc, 32'hC);
    tick();

    // Redirect + stall together, then stall alone
    drive(0, 1, 1, 32'h20); tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0);
      chk("rs_pc", instr_pc, 32'h20);
      tick();
    end

    // Wrap at the end of the ROM window
    drive(0, 0, 1, 32'hFFC);
    chk("wrap_addr0", 32'(Addr), 32'd1023);
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_pc0", instr_pc, 32'hFFC);
    chk("wrap_addr1", 32'(Addr), 32'd0);
    chk("wrap_instr0", instr, 32'h1000_03FF);
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_pc1", instr_pc, 32'h1000);
    chk("wrap_instr1", instr, 32'h1000_0000);
    tick();

    // Mid-stream reset pulse between edges
    drive(1, 0, 0, 0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_instr", instr, 32'd0);
    chk("mrst_cnt", fetch_cnt, 32'd0);
    chk("mrst_pc", instr_pc, RP);
    rst = 1'b0;
    tick();
    drive(0, 0, 0, 0);
    chk("restart_pc", instr_pc, RP);
    tick();

    // Randomized phase with fresh ROM contents, loaded while held in reset
    drive(1, 0, 0, 0);
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    tick();
    for (int n = 0; n < 3000; n++) begin
      int p;
      p = int'($urandom_range(199));
      if (p == 0) begin
        drive(1, 0, 0, 0);
        rst = 1'b0;
        tick();
      end else begin
        drive(p == 1, $urandom_range(2) == 0, $urandom_range(9) == 0, $urandom);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
